// File: rtl/gera_pulso.sv
// -----------------------------------------------------------------------------
// gera_pulso
//
// Purpose
//   Generates the timing signals for a clock display:
//   - a 1 Hz square wave, 50% duty, taken from a divider of the system clock;
//   - a one-cycle manual increment pulse for each debounced btn_inc press;
//   - a run/set mode select that toggles on each debounced btn_mode press.
//   Each raw button passes through a two-flop synchronizer and then its own
//   debounce FSM. A held button gives exactly one strobe (no auto-repeat).
//
// Ports
//   clk       in   system clock, rising edge active
//   reset     in   asynchronous, active-high reset
//   btn_mode  in   raw bouncing push button, toggles sel
//   btn_inc   in   raw bouncing push button, requests one Q pulse (set mode)
//   sel       out  1 = run (Hz drives downstream), 0 = set (Q drives it)
//   Q         out  one-cycle increment pulse per accepted btn_inc press
//   Hz        out  square wave with a period of exactly CLK_HZ cycles
// -----------------------------------------------------------------------------
module gera_pulso #(
   parameter int CLK_HZ     = 50000000,
   parameter int DEB_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_mode,
   input  logic btn_inc,
   output logic sel,
   output logic Q,
   output logic Hz
);

   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
   localparam int HALF  = CLK_HZ / 2;
   localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      CONF_PRESS   = 2'd1,
      HELD         = 2'd2,
      CONF_RELEASE = 2'd3
   } deb_state_t;

   // Saturating increment: the counter parks at DEB_CYCLES instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      if (c == DEB_MAX) begin
         return c;
      end
      return c + CNT_W'(1);
   endfunction

   // Bit 0 = btn_mode, bit 1 = btn_inc.
   logic [1:0] btn_raw;
   logic [1:0] sync1_q;
   logic [1:0] sync2_q;
   logic [1:0] strobe;

   assign btn_raw = {btn_inc, btn_mode};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_deb
      deb_state_t       state_q;
      deb_state_t       state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             in_s;
      logic             stb;

      assign in_s = sync2_q[b];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
         end
      end

      // The counter is cleared by default, so every state change and every
      // stay in IDLE/HELD starts the next confirmation run from zero. The
      // confirming sample is the one taken while cnt_q == DEB_CYCLES-1, so a
      // confirmation needs DEB_CYCLES consecutive samples inside CONF_*.
      always_comb begin
         state_d = state_q;
         cnt_d   = '0;
         stb     = 1'b0;
         case (state_q)
            IDLE: begin
               if (in_s) begin
                  state_d = CONF_PRESS;
               end
            end
            CONF_PRESS: begin
               if (!in_s) begin
                  state_d = IDLE;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = HELD;
                  stb     = 1'b1;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            HELD: begin
               if (!in_s) begin
                  state_d = CONF_RELEASE;
               end
            end
            CONF_RELEASE: begin
               if (in_s) begin
                  state_d = HELD;
               end else if (cnt_q == DEB_LAST) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = sat_inc(cnt_q);
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end

      assign strobe[b] = stb;
   end

   logic             sel_q;
   logic             sel_d;
   logic             q_q;
   logic             q_d;
   logic             hz_q;
   logic             hz_d;
   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] div_d;

   // The Q decision looks at the current sel_q, so a mode strobe landing in
   // the same cycle does not affect it (pre-toggle value wins).
   always_comb begin
      sel_d = sel_q ^ strobe[0];
      q_d   = strobe[1] & ~sel_q;
      hz_d  = hz_q;
      div_d = div_q + DIV_W'(1);
      if (div_q == DIV_LAST) begin
         div_d = '0;
         hz_d  = ~hz_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q <= 1'b1;
         q_q   <= 1'b0;
         hz_q  <= 1'b0;
         div_q <= '0;
      end else begin
         sel_q <= sel_d;
         q_q   <= q_d;
         hz_q  <= hz_d;
         div_q <= div_d;
      end
   end

   assign sel = sel_q;
   assign Q   = q_q;
   assign Hz  = hz_q;

endmodule

// File: tb/tb_gera_pulso.sv
module tb_gera_pulso;

   localparam int CLK  = 8;
   localparam int DEB  = 4;
   localparam int HALF = CLK / 2;

   logic clk;
   logic reset;
   logic btn_mode;
   logic btn_inc;
   logic sel;
   logic Q;
   logic Hz;

   int n_cmp = 0;
   int n_err = 0;
   int q_pulses = 0;

   gera_pulso #(
      .CLK_HZ    (CLK),
      .DEB_CYCLES(DEB)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .btn_mode(btn_mode),
      .btn_inc (btn_inc),
      .sel     (sel),
      .Q       (Q),
      .Hz      (Hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // A button level is accepted once the sampled (2-cycle delayed) input has
   // differed from the accepted level for DEB+1 consecutive samples: the
   // first differing sample opens the confirmation, DEB more confirm it.
   // A newly accepted high level yields one strobe in that same cycle.
   logic [1:0] m_d1, m_d2, m_acc;
   int         m_run [2];
   logic       m_sel, m_q;
   int         m_n;
   logic       m_hz;

   assign m_hz = ((m_n / HALF) % 2) == 1;

   always @(posedge clk or posedge reset) begin : ref_model
      logic [1:0] stb;
      int nrun;
      if (reset) begin
         m_d1     <= '0;
         m_d2     <= '0;
         m_acc    <= '0;
         m_run[0] <= 0;
         m_run[1] <= 0;
         m_sel    <= 1'b1;
         m_q      <= 1'b0;
         m_n      <= 0;
      end else begin
         stb = 2'b00;
         for (int b = 0; b < 2; b++) begin
            if (m_d2[b] != m_acc[b]) begin
               nrun = m_run[b] + 1;
               if (nrun == DEB + 1) begin
                  m_acc[b] <= m_d2[b];
                  m_run[b] <= 0;
                  stb[b]    = m_d2[b];
               end else begin
                  m_run[b] <= nrun;
               end
            end else begin
               m_run[b] <= 0;
            end
         end
         m_d1 <= {btn_inc, btn_mode};
         m_d2 <= m_d1;
         if (stb[0]) m_sel <= ~m_sel;
         m_q <= stb[1] && (m_sel == 1'b0);
         m_n <= m_n + 1;
      end
   end

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      check("model_sel", sel, m_sel);
      check("model_Q", Q, m_q);
      check("model_Hz", Hz, m_hz);
      if (Q === 1'b1) q_pulses++;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   int q0;

   initial begin
      reset    = 1'b1;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(2);
      check("rst_sel", sel, 1'b1);
      check("rst_Q", Q, 1'b0);
      check("rst_Hz", Hz, 1'b0);
      reset = 1'b0;

      // Free run: first Hz toggle on the 4th edge after release.
      step(3);
      check("hz_before_first_toggle", Hz, 1'b0);
      step(1);
      check("hz_first_toggle", Hz, 1'b1);
      step(4);
      check("hz_second_toggle", Hz, 1'b0);
      step(24);
      check("freerun_sel", sel, 1'b1);

      // Mode press: sel toggles on the 7th edge after the rise, once.
      btn_mode = 1'b1;
      step(6);
      check("mode_sel_before", sel, 1'b1);
      step(1);
      check("mode_sel_after", sel, 1'b0);
      step(3);
      btn_mode = 1'b0;
      step(12);
      check("mode_no_repeat", sel, 1'b0);

      // Bouncing inc press in set mode: exactly one pulse.
      q0 = q_pulses;
      btn_inc = 1'b1; step(1);
      btn_inc = 1'b0; step(1);
      btn_inc = 1'b1; step(1);
      btn_inc = 1'b0; step(1);
      btn_inc = 1'b1; step(6);
      btn_inc = 1'b0; step(12);
      check_int("bounce_q_pulses", q_pulses - q0, 1);

      // Both strobes in the same cycle: Q uses pre-toggle sel.
      q0 = q_pulses;
      btn_mode = 1'b1;
      btn_inc  = 1'b1;
      step(8);
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(12);
      check_int("both_q_pulses", q_pulses - q0, 1);
      check("both_sel", sel, 1'b1);

      // Run mode: inc press discarded.
      q0 = q_pulses;
      btn_inc = 1'b1; step(8);
      btn_inc = 1'b0; step(12);
      check_int("run_q_pulses", q_pulses - q0, 0);
      check("run_sel", sel, 1'b1);

      // Reset during CONF_PRESS of btn_inc with sel=0.
      btn_mode = 1'b1; step(8);
      btn_mode = 1'b0; step(12);
      check("abort_pre_sel", sel, 1'b0);
      q0 = q_pulses;
      btn_inc = 1'b1;
      step(4);
      reset   = 1'b1;
      btn_inc = 1'b0;
      #1;
      check("abort_sel_async", sel, 1'b1);
      check("abort_Q_async", Q, 1'b0);
      check("abort_Hz_async", Hz, 1'b0);
      step(1);
      reset = 1'b0;
      step(20);
      check_int("abort_q_pulses", q_pulses - q0, 0);
      check("abort_sel_after", sel, 1'b1);

      // Randomized phase: alternating busy/quiet button activity, rare resets.
      for (int i = 0; i < 3000; i++) begin
         if (((i / 200) % 2) == 0) begin
            if ($urandom_range(0, 5) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 4) == 0) btn_inc  = ~btn_inc;
         end else begin
            if ($urandom_range(0, 19) == 0) btn_mode = ~btn_mode;
            if ($urandom_range(0, 14) == 0) btn_inc  = ~btn_inc;
         end
         reset = ($urandom_range(0, 599) == 0);
         step(1);
      end
      reset    = 1'b0;
      btn_mode = 1'b0;
      btn_inc  = 1'b0;
      step(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
